// File: rtl/ad5318_rx.sv
// AD5318 serial-link slave: oversamples SCLK/DIN/SYNC_b/LDAC_b in the clkin domain,
// assembles 16-bit frames and maintains per-channel input/DAC registers and control state.
module ad5318_rx #(
  parameter int NCH         = 8,
  parameter int DW          = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clkin,
  input  logic              rstn,
  input  logic              SCLK,
  input  logic              SYNC_b,
  input  logic              DIN,
  input  logic              LDAC_b,
  output logic [NCH*DW-1:0] dac_code,
  output logic [NCH-1:0]    dac_upd,
  output logic [NCH-1:0]    pd,
  output logic [5:0]        gain_buf,
  output logic [1:0]        ldac_mode,
  output logic [15:0]       rx_word,
  output logic              rx_valid,
  output logic              frame_err
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  // Synchronizers reset to 0 so that a SYNC_b already low at reset release
  // produces no falling edge until it has been seen high.
  logic [3:0] r_sync [SYNC_STAGES];
  logic [2:0] r_prev;
  logic       w_sclk_s, w_din_s, w_sync_s, w_ldac_s;
  logic       w_sclk_fall, w_sync_fall, w_sync_rise, w_ldac_fall;

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= {LDAC_b, SYNC_b, DIN, SCLK};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= {w_ldac_s, w_sync_s, w_sclk_s};
    end
  end

  assign {w_ldac_s, w_sync_s, w_din_s, w_sclk_s} = r_sync[SYNC_STAGES-1];
  assign w_sclk_fall = r_prev[0] & ~w_sclk_s;
  assign w_sync_fall = r_prev[1] & ~w_sync_s;
  assign w_sync_rise = ~r_prev[1] & w_sync_s;
  assign w_ldac_fall = r_prev[2] & ~w_ldac_s;

  state_t      r_state, w_next_state;
  logic [4:0]  r_cnt;
  logic [15:0] r_shift;
  logic [15:0] w_word;
  logic        w_shift_en, w_word_done, w_abort;

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: combinational blocks use blocking '=' with every output defaulted
  // first, so no path through the block leaves a signal unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_shift_en   = 1'b0;
    w_word_done  = 1'b0;
    w_abort      = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_sync_fall) w_next_state = S_SHIFT;
      S_SHIFT: begin
        if (w_sync_rise) begin
          w_next_state = S_IDLE;
          w_abort      = (r_cnt != 5'd0);
        end else if (w_sclk_fall) begin
          w_shift_en = 1'b1;
          if (r_cnt == 5'd15) begin
            w_word_done  = 1'b1;
            w_next_state = S_DONE;
          end
        end
      end
      S_DONE:  if (w_sync_rise) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_word = {r_shift[14:0], w_din_s};

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if (w_shift_en) begin
      r_cnt   <= r_cnt + 5'd1;
      r_shift <= w_word;
    end
  end

  logic [DW-1:0]  r_inreg [NCH];
  logic [DW-1:0]  r_dacreg [NCH];
  logic [DW-1:0]  w_inreg_nx [NCH];
  logic [DW-1:0]  w_dacreg_nx [NCH];
  logic [NCH-1:0] r_pd, w_pd_nx, r_upd, w_upd_nx;
  logic [5:0]     r_gain, w_gain_nx;
  logic [1:0]     r_mode, w_mode_nx;
  logic [15:0]    r_rx_word;
  logic           r_rx_valid, r_frame_err;

  always_comb begin
    w_inreg_nx  = r_inreg;
    w_dacreg_nx = r_dacreg;
    w_upd_nx    = '0;
    w_pd_nx     = r_pd;
    w_gain_nx   = r_gain;
    // Single-update mode lasts exactly one cycle, then falls back to mode 01.
    w_mode_nx   = (r_mode == 2'b10) ? 2'b01 : r_mode;
    if (w_word_done) begin
      if (!w_word[15]) begin
        w_inreg_nx[w_word[14:12]] = w_word[11:2];
        if (r_mode == 2'b00) begin
          w_dacreg_nx[w_word[14:12]] = w_word[11:2];
          w_upd_nx[w_word[14:12]]    = 1'b1;
        end
      end else begin
        unique case (w_word[14:13])
          2'b00: w_gain_nx = w_word[5:0];
          2'b01: begin
            if (w_word[1:0] != 2'b11) w_mode_nx = w_word[1:0];
            if (w_word[1:0] == 2'b10) begin
              w_dacreg_nx = r_inreg;
              w_upd_nx    = '1;
            end
          end
          2'b10: w_pd_nx = w_word[NCH-1:0];
          2'b11: begin
            for (int i = 0; i < NCH; i++) begin
              w_inreg_nx[i]  = '0;
              w_dacreg_nx[i] = '0;
            end
            w_upd_nx = '1;
            if (w_word[12]) begin
              w_pd_nx   = '0;
              w_gain_nx = '0;
              w_mode_nx = 2'b00;
            end
          end
          default: ;
        endcase
      end
    end
    // Loading from the post-write input regs gives write-through on a coincident write.
    if (w_ldac_fall && (r_mode == 2'b01 || r_mode == 2'b10)) begin
      w_dacreg_nx = w_inreg_nx;
      w_upd_nx    = '1;
    end
  end

  // NOTE: the register file is small and must read zero after reset, so it is
  // reset explicitly rather than being inferred as a RAM without reset.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        r_inreg[i]  <= '0;
        r_dacreg[i] <= '0;
      end
      r_pd        <= '0;
      r_upd       <= '0;
      r_gain      <= '0;
      r_mode      <= 2'b00;
      r_rx_word   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_inreg     <= w_inreg_nx;
      r_dacreg    <= w_dacreg_nx;
      r_pd        <= w_pd_nx;
      r_upd       <= w_upd_nx;
      r_gain      <= w_gain_nx;
      r_mode      <= w_mode_nx;
      r_rx_valid  <= w_word_done;
      r_frame_err <= w_abort;
      if (w_word_done) r_rx_word <= w_word;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign dac_code[g*DW +: DW] = r_dacreg[g];
  end

  assign dac_upd   = r_upd;
  assign pd        = r_pd;
  assign gain_buf  = r_gain;
  assign ldac_mode = r_mode;
  assign rx_word   = r_rx_word;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ad5318_rx.sv
// Self-checking bench for ad5318_rx: directed scenarios plus random frames against a
// register-level model of the command set.
module tb_ad5318_rx;

  localparam int NCH = 8;
  localparam int DW  = 10;

  logic clkin = 1'b0;
  logic rstn, SCLK, SYNC_b, DIN, LDAC_b;
  logic [NCH*DW-1:0] dac_code;
  logic [NCH-1:0]    dac_upd, pd;
  logic [5:0]        gain_buf;
  logic [1:0]        ldac_mode;
  logic [15:0]       rx_word;
  logic              rx_valid, frame_err;

  ad5318_rx #(.NCH(NCH), .DW(DW), .SYNC_STAGES(2)) dut (
    .clkin(clkin), .rstn(rstn), .SCLK(SCLK), .SYNC_b(SYNC_b), .DIN(DIN), .LDAC_b(LDAC_b),
    .dac_code(dac_code), .dac_upd(dac_upd), .pd(pd), .gain_buf(gain_buf),
    .ldac_mode(ldac_mode), .rx_word(rx_word), .rx_valid(rx_valid), .frame_err(frame_err)
  );

  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor: snapshot outputs in the rx_valid cycle, count pulses.
  int n_valid = 0, n_ferr = 0, n_upd = 0;
  logic [15:0]       cap_word;
  logic [NCH*DW-1:0] cap_code;
  logic [NCH-1:0]    cap_upd, last_upd;
  logic [1:0]        cap_mode;

  always @(negedge clkin) begin
    if (rstn) begin
      if (rx_valid) begin
        n_valid++;
        cap_word = rx_word;
        cap_code = dac_code;
        cap_upd  = dac_upd;
        cap_mode = ldac_mode;
      end
      if (frame_err) n_ferr++;
      if (dac_upd != '0) begin
        n_upd++;
        last_upd = dac_upd;
      end
    end
  end

  // Reference model: the DAC register file as the command set describes it.
  logic [DW-1:0]  m_in [NCH];
  logic [DW-1:0]  m_dac [NCH];
  logic [NCH-1:0] m_pd, m_upd;
  logic [5:0]     m_gain;
  logic [1:0]     m_mode, m_mode_v;

  function automatic logic [NCH*DW-1:0] m_code();
    logic [NCH*DW-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*DW +: DW] = m_dac[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin m_in[i] = '0; m_dac[i] = '0; end
    m_pd = '0; m_upd = '0; m_gain = '0; m_mode = 2'b00; m_mode_v = 2'b00;
  endtask

  task automatic model_word(input logic [15:0] w, input bit ldac_same);
    logic [1:0] old_mode;
    bit single;
    old_mode = m_mode;
    single   = 1'b0;
    m_upd    = '0;
    if (!w[15]) begin
      m_in[w[14:12]] = w[11:2];
      if (old_mode == 2'b00) begin m_dac[w[14:12]] = w[11:2]; m_upd[w[14:12]] = 1'b1; end
    end else if (w[14:13] == 2'b00) begin
      m_gain = w[5:0];
    end else if (w[14:13] == 2'b01) begin
      if (w[1:0] == 2'b10) begin
        for (int i = 0; i < NCH; i++) m_dac[i] = m_in[i];
        m_upd = '1; m_mode = 2'b01; single = 1'b1;
      end else if (w[1:0] != 2'b11) begin
        m_mode = w[1:0];
      end
    end else if (w[14:13] == 2'b10) begin
      m_pd = w[NCH-1:0];
    end else begin
      for (int i = 0; i < NCH; i++) begin m_in[i] = '0; m_dac[i] = '0; end
      m_upd = '1;
      if (w[12]) begin m_pd = '0; m_gain = '0; m_mode = 2'b00; end
    end
    m_mode_v = single ? 2'b10 : m_mode;
    if (ldac_same && old_mode == 2'b01) begin
      for (int i = 0; i < NCH; i++) m_dac[i] = m_in[i];
      m_upd = '1;
    end
  endtask

  task automatic model_ldac();
    m_upd = '0;
    if (m_mode == 2'b01) begin
      for (int i = 0; i < NCH; i++) m_dac[i] = m_in[i];
      m_upd = '1;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clkin);
  endtask

  // SCLK phases of 4 clkin periods; DIN changes while SCLK is high.
  task automatic send_bits(input logic [15:0] w, input int nbits, input bit ldac_last);
    for (int i = 0; i < nbits; i++) begin
      DIN = w[15-i];
      wait_cyc(4);
      SCLK = 1'b0;
      if (ldac_last && i == 15) LDAC_b = 1'b0;
      wait_cyc(4);
      SCLK = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [15:0] w, input int nbits, input bit ldac_last);
    SYNC_b = 1'b0;
    wait_cyc(4);
    send_bits(w, nbits, ldac_last);
    wait_cyc(4);
    SYNC_b = 1'b1;
    LDAC_b = 1'b1;
    wait_cyc(8);
  endtask

  task automatic pulse_ldac();
    LDAC_b = 1'b0;
    wait_cyc(8);
    LDAC_b = 1'b1;
    wait_cyc(8);
  endtask

  task automatic test_reset();
    rstn = 1'b0; SCLK = 1'b1; SYNC_b = 1'b1; DIN = 1'b0; LDAC_b = 1'b1;
    model_reset();
    wait_cyc(3);
    n_checks++; if (dac_code !== '0) begin n_fail++; $display("FAIL reset_dac_code: got %h exp 0", dac_code); end
    n_checks++; if ({dac_upd, pd} !== '0) begin n_fail++; $display("FAIL reset_upd_pd: got %h exp 0", {dac_upd, pd}); end
    n_checks++; if ({gain_buf, ldac_mode} !== '0) begin n_fail++; $display("FAIL reset_gain_mode: got %h exp 0", {gain_buf, ldac_mode}); end
    n_checks++; if ({rx_word, rx_valid, frame_err} !== '0) begin n_fail++; $display("FAIL reset_rx: got %h exp 0", {rx_word, rx_valid, frame_err}); end
    rstn = 1'b1;
    wait_cyc(5);
  endtask

  task automatic test_gain();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(16'h8030, 16, 1'b0); model_word(16'h8030, 1'b0);
    n_checks++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL gain_valid_count: got %0d exp 1", n_valid - v0); end
    n_checks++; if (cap_word !== 16'h8030) begin n_fail++; $display("FAIL gain_rx_word: got %h exp 8030", cap_word); end
    n_checks++; if (gain_buf !== 6'b110000) begin n_fail++; $display("FAIL gain_buf: got %b exp 110000", gain_buf); end
    n_checks++; if (n_ferr !== f0) begin n_fail++; $display("FAIL gain_frame_err: got %0d exp %0d", n_ferr, f0); end
  endtask

  task automatic test_data_mode00();
    send_frame(16'hC000, 16, 1'b0); model_word(16'hC000, 1'b0);
    send_frame(16'h4004, 16, 1'b0); model_word(16'h4004, 1'b0);
    n_checks++; if (pd !== 8'h00) begin n_fail++; $display("FAIL d00_pd: got %h exp 00", pd); end
    n_checks++; if (cap_code[4*DW +: DW] !== 10'd1) begin n_fail++; $display("FAIL d00_code_e: got %h exp 001", cap_code[4*DW +: DW]); end
    n_checks++; if (cap_upd !== 8'h10) begin n_fail++; $display("FAIL d00_upd: got %h exp 10", cap_upd); end
    n_checks++; if (dac_code !== m_code()) begin n_fail++; $display("FAIL d00_all_codes: got %h exp %h", dac_code, m_code()); end
  endtask

  task automatic test_ldac_mode01();
    int u0;
    send_frame(16'hA001, 16, 1'b0); model_word(16'hA001, 1'b0);
    send_frame(16'h4FFC, 16, 1'b0); model_word(16'h4FFC, 1'b0);
    n_checks++; if (ldac_mode !== 2'b01) begin n_fail++; $display("FAIL m01_mode: got %b exp 01", ldac_mode); end
    n_checks++; if (dac_code[4*DW +: DW] !== 10'd1) begin n_fail++; $display("FAIL m01_code_e_held: got %h exp 001", dac_code[4*DW +: DW]); end
    last_upd = '0; u0 = n_upd;
    pulse_ldac(); model_ldac();
    n_checks++; if (dac_code[4*DW +: DW] !== 10'h3FF) begin n_fail++; $display("FAIL m01_code_e_ldac: got %h exp 3ff", dac_code[4*DW +: DW]); end
    n_checks++; if (last_upd !== 8'hFF) begin n_fail++; $display("FAIL m01_upd: got %h exp ff", last_upd); end
    n_checks++; if (n_upd - u0 !== 1) begin n_fail++; $display("FAIL m01_upd_width: got %0d exp 1", n_upd - u0); end
  endtask

  task automatic test_single_update();
    send_frame(16'h1200, 16, 1'b0); model_word(16'h1200, 1'b0);
    n_checks++; if (dac_code[1*DW +: DW] !== 10'h000) begin n_fail++; $display("FAIL su_code_b_held: got %h exp 000", dac_code[1*DW +: DW]); end
    send_frame(16'hA002, 16, 1'b0); model_word(16'hA002, 1'b0);
    n_checks++; if (cap_code[1*DW +: DW] !== 10'h080) begin n_fail++; $display("FAIL su_code_b: got %h exp 080", cap_code[1*DW +: DW]); end
    n_checks++; if (cap_upd !== 8'hFF) begin n_fail++; $display("FAIL su_upd: got %h exp ff", cap_upd); end
    n_checks++; if (cap_mode !== 2'b10) begin n_fail++; $display("FAIL su_mode_valid_cycle: got %b exp 10", cap_mode); end
    n_checks++; if (ldac_mode !== 2'b01) begin n_fail++; $display("FAIL su_mode_after: got %b exp 01", ldac_mode); end
  endtask

  task automatic test_frame_abort();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(16'h0FFC, 9, 1'b0);
    n_checks++; if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL abort_ferr_pulses: got %0d exp 1", n_ferr - f0); end
    n_checks++; if (n_valid !== v0) begin n_fail++; $display("FAIL abort_no_valid: got %0d exp %0d", n_valid, v0); end
    n_checks++; if ({dac_code, pd, gain_buf, ldac_mode} !== {m_code(), m_pd, m_gain, m_mode}) begin
      n_fail++; $display("FAIL abort_state: got %h exp %h", {dac_code, pd, gain_buf, ldac_mode}, {m_code(), m_pd, m_gain, m_mode}); end
    send_frame(16'h3154, 16, 1'b0); model_word(16'h3154, 1'b0);
    n_checks++; if (n_valid - v0 !== 1 || cap_word !== 16'h3154) begin
      n_fail++; $display("FAIL abort_next_frame: got %0d/%h exp 1/3154", n_valid - v0, cap_word); end
  endtask

  task automatic test_write_through();
    send_frame(16'h2AA8, 16, 1'b1); model_word(16'h2AA8, 1'b1);
    n_checks++; if (cap_code !== m_code()) begin n_fail++; $display("FAIL wt_codes: got %h exp %h", cap_code, m_code()); end
    n_checks++; if (cap_code[2*DW +: DW] !== 10'h2AA) begin n_fail++; $display("FAIL wt_code_c: got %h exp 2aa", cap_code[2*DW +: DW]); end
    n_checks++; if (cap_upd !== 8'hFF) begin n_fail++; $display("FAIL wt_upd: got %h exp ff", cap_upd); end
  endtask

  task automatic test_reset_cmd();
    send_frame(16'h8015, 16, 1'b0); model_word(16'h8015, 1'b0);
    send_frame(16'hC00F, 16, 1'b0); model_word(16'hC00F, 1'b0);
    n_checks++; if (pd !== 8'h0F) begin n_fail++; $display("FAIL rc_pd_set: got %h exp 0f", pd); end
    send_frame(16'hF000, 16, 1'b0); model_word(16'hF000, 1'b0);
    n_checks++; if (dac_code !== '0) begin n_fail++; $display("FAIL rc_codes: got %h exp 0", dac_code); end
    n_checks++; if ({pd, gain_buf, ldac_mode} !== '0) begin n_fail++; $display("FAIL rc_ctrl: got %h exp 0", {pd, gain_buf, ldac_mode}); end
    n_checks++; if (cap_upd !== 8'hFF) begin n_fail++; $display("FAIL rc_upd: got %h exp ff", cap_upd); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [15:0] w;
    int sel, v0, u0;
    bit ldac;
    for (int it = 0; it < 30; it++) begin
      r = $urandom(); sel = $urandom_range(0, 9); ldac = 1'b0;
      case (sel)
        0, 1, 2, 3, 4: begin w = {1'b0, r[14:0]}; ldac = r[31]; end
        5: w = {3'b100, r[12:0]};
        6: w = {3'b101, r[12:0]};
        7: w = {3'b110, r[12:0]};
        8: w = {3'b111, r[12:0]};
        default: w = '0;
      endcase
      if (sel == 9) begin
        last_upd = '0; u0 = n_upd;
        pulse_ldac(); model_ldac();
        n_checks++; if (dac_code !== m_code() || last_upd !== m_upd) begin
          n_fail++; $display("FAIL rnd_ldac[%0d]: got %h/%h exp %h/%h", it, dac_code, last_upd, m_code(), m_upd); end
      end else begin
        v0 = n_valid;
        send_frame(w, 16, ldac); model_word(w, ldac);
        n_checks++; if (n_valid - v0 !== 1 || cap_word !== w) begin
          n_fail++; $display("FAIL rnd_rx[%0d]: got %0d/%h exp 1/%h", it, n_valid - v0, cap_word, w); end
        n_checks++; if (cap_code !== m_code() || cap_upd !== m_upd || cap_mode !== m_mode_v) begin
          n_fail++; $display("FAIL rnd_regs[%0d] w=%h: got %h/%h/%b exp %h/%h/%b", it, w, cap_code, cap_upd, cap_mode, m_code(), m_upd, m_mode_v); end
        n_checks++; if ({pd, gain_buf, ldac_mode} !== {m_pd, m_gain, m_mode}) begin
          n_fail++; $display("FAIL rnd_ctrl[%0d] w=%h: got %h exp %h", it, w, {pd, gain_buf, ldac_mode}, {m_pd, m_gain, m_mode}); end
      end
    end
  endtask

  task automatic test_mid_reset();
    int v0, f0;
    send_frame(16'hA000, 16, 1'b0); model_word(16'hA000, 1'b0);
    send_frame(16'h4004, 16, 1'b0); model_word(16'h4004, 1'b0);
    send_frame(16'h8015, 16, 1'b0); model_word(16'h8015, 1'b0);
    SYNC_b = 1'b0;
    wait_cyc(4);
    send_bits(16'h7FFC, 5, 1'b0);
    rstn = 1'b0;
    #1;
    model_reset();
    n_checks++; if (dac_code !== '0) begin n_fail++; $display("FAIL mr_codes: got %h exp 0", dac_code); end
    n_checks++; if ({pd, gain_buf, ldac_mode, rx_word} !== '0) begin n_fail++; $display("FAIL mr_ctrl: got %h exp 0", {pd, gain_buf, ldac_mode, rx_word}); end
    wait_cyc(3);
    rstn = 1'b1;
    v0 = n_valid; f0 = n_ferr;
    send_bits(16'h7FFC, 16, 1'b0);
    wait_cyc(4);
    SYNC_b = 1'b1;
    wait_cyc(8);
    n_checks++; if (n_valid !== v0 || n_ferr !== f0 || dac_code !== '0) begin
      n_fail++; $display("FAIL mr_low_sync_ignored: got %0d/%0d/%h exp %0d/%0d/0", n_valid, n_ferr, dac_code, v0, f0); end
    send_frame(16'h8015, 16, 1'b0); model_word(16'h8015, 1'b0);
    n_checks++; if (n_valid - v0 !== 1 || gain_buf !== 6'h15) begin
      n_fail++; $display("FAIL mr_next_frame: got %0d/%h exp 1/15", n_valid - v0, gain_buf); end
  endtask

  initial begin
    test_reset();
    test_gain();
    test_data_mode00();
    test_ldac_mode01();
    test_single_update();
    test_frame_abort();
    test_write_through();
    test_reset_cmd();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
